// File: rtl/eth_tx_framer_if.sv
// Byte-stream ingress and GMII-style egress bundle for eth_tx_framer.
// master: upstream source / monitor side; slave: the framer itself.
interface eth_tx_framer_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [7:0]  tx_data;
    logic [1:0]  tx_ctl;
    logic        underrun;
    logic [15:0] frames_sent;

    modport master (
        output in_data, in_valid, in_last,
        input  in_ready, tx_data, tx_ctl, underrun, frames_sent
    );

    modport slave (
        input  in_data, in_valid, in_last,
        output in_ready, tx_data, tx_ctl, underrun, frames_sent
    );
endinterface

// File: rtl/eth_tx_framer.sv
// Ethernet TX framer: preamble/SFD insertion, CRC-32 FCS append, underrun abort, IFG.
// Define ETH_TX_PAD_EN to pad short frames with zeros up to MIN_FRAME bytes before the FCS.
module eth_tx_framer #(
    parameter int IFG_BYTES = 12,
    parameter int MIN_FRAME = 60
) (
    input logic           clk,
    input logic           nreset,
    eth_tx_framer_if.slave bus
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PREAMBLE = 3'd1;
    localparam logic [2:0] S_SFD      = 3'd2;
    localparam logic [2:0] S_DATA     = 3'd3;
    localparam logic [2:0] S_PAD      = 3'd4;
    localparam logic [2:0] S_FCS      = 3'd5;
    localparam logic [2:0] S_DISCARD  = 3'd6;
    localparam logic [2:0] S_IFG      = 3'd7;

    localparam logic [1:0]  CTL_IDLE = 2'b00;
    localparam logic [1:0]  CTL_ERR  = 2'b01;
    localparam logic [1:0]  CTL_DATA = 2'b11;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

    localparam logic [15:0] MIN_FRAME_W = 16'(MIN_FRAME);
    localparam logic [15:0] IFG_LAST    = 16'(IFG_BYTES - 1);

`ifdef ETH_TX_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    // Reflected CRC-32 (poly 0x04C11DB7) advanced by one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h00_0000, data};
        for (int b = 0; b < 32'sd8; b++) begin
            if (c[0]) begin
                c = (c >> 1) ^ 32'hEDB8_8320;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    logic [2:0]  state_q,    state_d;
    logic [15:0] timer_q,    timer_d;
    logic [15:0] cnt_q,      cnt_d;
    logic [31:0] crc_q,      crc_d;
    logic [7:0]  tx_data_q,  tx_data_d;
    logic [1:0]  tx_ctl_q,   tx_ctl_d;
    logic        in_ready_q, in_ready_d;
    logic        underrun_q, underrun_d;
    logic [15:0] frames_q,   frames_d;

    logic        accept_s;
    logic [15:0] cnt_inc_s;
    logic [31:0] fcs_s;

    assign accept_s  = bus.in_valid & in_ready_q;
    assign cnt_inc_s = (cnt_q == 16'hFFFF) ? cnt_q : (cnt_q + 16'd1);
    assign fcs_s     = ~crc_q;

    // Next-state and next-output logic; every output is one register stage behind its decision.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        cnt_d      = cnt_q;
        crc_d      = crc_q;
        tx_data_d  = 8'h00;
        tx_ctl_d   = CTL_IDLE;
        underrun_d = 1'b0;
        frames_d   = frames_q;

        case (state_q)
            S_IDLE: begin
                crc_d   = CRC_INIT;
                cnt_d   = 16'd0;
                timer_d = 16'd0;
                // The first preamble byte is launched here so the IFG gap stays exactly IFG_BYTES.
                if (bus.in_valid) begin
                    state_d   = S_PREAMBLE;
                    tx_data_d = 8'h55;
                    tx_ctl_d  = CTL_DATA;
                    timer_d   = 16'd1;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_PREAMBLE: begin
                tx_data_d = 8'h55;
                tx_ctl_d  = CTL_DATA;
                if (timer_q == 16'd6) begin
                    state_d = S_SFD;
                    timer_d = 16'd0;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end

            S_SFD: begin
                tx_data_d = 8'hD5;
                tx_ctl_d  = CTL_DATA;
                state_d   = S_DATA;
            end

            S_DATA: begin
                if (accept_s) begin
                    tx_data_d = bus.in_data;
                    tx_ctl_d  = CTL_DATA;
                    crc_d     = crc32_byte(crc_q, bus.in_data);
                    cnt_d     = cnt_inc_s;
                    if (bus.in_last) begin
                        timer_d = 16'd0;
                        if (PAD_EN && (cnt_inc_s < MIN_FRAME_W)) begin
                            state_d = S_PAD;
                        end else begin
                            state_d = S_FCS;
                        end
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    tx_data_d  = 8'h00;
                    tx_ctl_d   = CTL_ERR;
                    underrun_d = 1'b1;
                    state_d    = S_DISCARD;
                end
            end

`ifdef ETH_TX_PAD_EN
            S_PAD: begin
                tx_data_d = 8'h00;
                tx_ctl_d  = CTL_DATA;
                crc_d     = crc32_byte(crc_q, 8'h00);
                cnt_d     = cnt_inc_s;
                if (cnt_inc_s >= MIN_FRAME_W) begin
                    state_d = S_FCS;
                    timer_d = 16'd0;
                end else begin
                    state_d = S_PAD;
                end
            end
`endif

            S_FCS: begin
                tx_data_d = fcs_s[{timer_q[1:0], 3'b000} +: 8];
                tx_ctl_d  = CTL_DATA;
                if (timer_q[1:0] == 2'd3) begin
                    frames_d = frames_q + 16'd1;
                    state_d  = S_IFG;
                    timer_d  = 16'd0;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end

            S_DISCARD: begin
                if (accept_s && bus.in_last) begin
                    state_d = S_IFG;
                    timer_d = 16'd0;
                end else begin
                    state_d = S_DISCARD;
                end
            end

            S_IFG: begin
                if (timer_q >= IFG_LAST) begin
                    state_d = S_IDLE;
                    timer_d = 16'd0;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
                timer_d = 16'd0;
            end
        endcase

        in_ready_d = (state_d == S_DATA) || (state_d == S_DISCARD);
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q    <= S_IDLE;
            timer_q    <= 16'd0;
            cnt_q      <= 16'd0;
            crc_q      <= CRC_INIT;
            tx_data_q  <= 8'h00;
            tx_ctl_q   <= CTL_IDLE;
            in_ready_q <= 1'b0;
            underrun_q <= 1'b0;
            frames_q   <= 16'd0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            cnt_q      <= cnt_d;
            crc_q      <= crc_d;
            tx_data_q  <= tx_data_d;
            tx_ctl_q   <= tx_ctl_d;
            in_ready_q <= in_ready_d;
            underrun_q <= underrun_d;
            frames_q   <= frames_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_ctl      = tx_ctl_q;
    assign bus.underrun    = underrun_q;
    assign bus.frames_sent = frames_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed/randomized bench for eth_tx_framer with a frame-level reference model.
module tb_eth_tx_framer;

    typedef logic [7:0] bq_t[$];

    localparam int IFG  = 12;
    localparam int MINF = 60;
`ifdef ETH_TX_PAD_EN
    localparam int LEN_123 = 72;
`else
    localparam int LEN_123 = 21;
`endif

    logic clk    = 1'b0;
    logic nreset = 1'b0;

    eth_tx_framer_if bus();

    eth_tx_framer #(.IFG_BYTES(IFG), .MIN_FRAME(MINF)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    always #4 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_frames;

    logic       log_en = 1'b0;
    logic [1:0] l_ctl[$];
    logic [7:0] l_data[$];
    logic       l_und[$];

    always @(negedge clk) begin
        if (log_en) begin
            l_ctl.push_back(bus.tx_ctl);
            l_data.push_back(bus.tx_data);
            l_und.push_back(bus.underrun);
        end
    end

    logic [7:0] obs[$];
    int blen[$];
    int gaps[$];
    int n_err, n_und, err_idx, und_idx, last11;
    logic [7:0] err_data;

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Reference FCS: bit-serial reflected CRC-32 over the whole frame body.
    function automatic logic [31:0] crc32(input bq_t d);
        logic [31:0] c;
        logic fb;
        c = 32'hFFFF_FFFF;
        foreach (d[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ d[i][b];
                c  = (c >> 1) ^ (fb ? 32'hEDB8_8320 : 32'h0);
            end
        end
        return ~c;
    endfunction

    function automatic bq_t frame_of(input bq_t p);
        bq_t body, f;
        logic [31:0] fcs;
        foreach (p[i]) body.push_back(p[i]);
`ifdef ETH_TX_PAD_EN
        while (body.size() < MINF) body.push_back(8'h00);
`endif
        fcs = crc32(body);
        for (int i = 0; i < 7; i++) f.push_back(8'h55);
        f.push_back(8'hD5);
        foreach (body[i]) f.push_back(body[i]);
        for (int i = 0; i < 4; i++) f.push_back(fcs[8*i +: 8]);
        return f;
    endfunction

    function automatic bq_t rand_payload(input int n);
        bq_t p;
        for (int i = 0; i < n; i++) p.push_back(8'($urandom_range(0, 255)));
        return p;
    endfunction

    task automatic start_log();
        l_ctl.delete();
        l_data.delete();
        l_und.delete();
        log_en = 1'b1;
    endtask

    task automatic wait_end();
        repeat (100) @(posedge clk);
        #1;
        log_en = 1'b0;
    endtask

    // Drive a payload; stall_at drops in_valid for one cycle after that many bytes,
    // abort_at returns early while that byte index is still being presented.
    task automatic send(input bq_t p, input int stall_at, input int abort_at);
        int i, cyc;
        bit acc, stalled;
        i = 0; cyc = 0; stalled = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = p[0];
        bus.in_last  = (p.size() == 1);
        while (i < p.size() && i != abort_at && cyc < 2000) begin
            @(negedge clk);
            acc = bus.in_ready && bus.in_valid;
            @(posedge clk);
            #1;
            cyc++;
            if (acc) i++;
            if (acc && i == stall_at && !stalled) begin
                bus.in_valid = 1'b0;
                stalled = 1'b1;
            end else begin
                bus.in_valid = (i < p.size());
            end
            if (i < p.size()) begin
                bus.in_data = p[i];
                bus.in_last = (i == p.size() - 1);
            end
        end
        check("send_bound", {31'd0, cyc < 2000}, 32'd1);
    endtask

    task automatic analyse();
        int run_idle;
        bit in_b;
        obs.delete(); blen.delete(); gaps.delete();
        n_err = 0; n_und = 0; err_idx = -1; und_idx = -1; last11 = -1; err_data = 8'hxx;
        run_idle = 0; in_b = 1'b0;
        for (int k = 0; k < l_ctl.size(); k++) begin
            if (l_und[k] === 1'b1) begin n_und++; und_idx = k; end
            if (l_ctl[k] === 2'b11) begin
                if (!in_b) begin
                    if (blen.size() > 0) gaps.push_back(run_idle);
                    blen.push_back(0);
                    in_b = 1'b1;
                end
                blen[blen.size()-1] = blen[blen.size()-1] + 1;
                obs.push_back(l_data[k]);
                last11 = k;
            end else begin
                if (in_b) run_idle = 0;
                in_b = 1'b0;
                if (l_ctl[k] === 2'b01) begin n_err++; err_idx = k; err_data = l_data[k]; end
                else run_idle++;
            end
        end
    endtask

    task automatic check_burst(input string tag, input int bi, input bq_t e);
        int off;
        off = 0;
        for (int k = 0; k < bi && k < blen.size(); k++) off += blen[k];
        if (bi < blen.size()) begin
            check({tag, "_len"}, blen[bi], e.size());
            for (int j = 0; j < e.size() && j < blen[bi]; j++)
                check($sformatf("%s_b%0d", tag, j), obs[off+j], e[j]);
        end else begin
            check({tag, "_missing"}, blen.size(), bi + 1);
        end
    endtask

    task automatic one_frame(input string tag, input bq_t p);
        start_log();
        send(p, -1, -1);
        wait_end();
        analyse();
        exp_frames = exp_frames + 16'd1;
        check({tag, "_nbursts"}, blen.size(), 1);
        check_burst(tag, 0, frame_of(p));
        check({tag, "_frames"}, bus.frames_sent, exp_frames);
    endtask

    initial begin
        bq_t p, pa, pb, e13, fr;

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_last  = 1'b0;
        nreset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctl",      bus.tx_ctl,      2'b00);
        check("rst_data",     bus.tx_data,     8'h00);
        check("rst_ready",    bus.in_ready,    1'b0);
        check("rst_underrun", bus.underrun,    1'b0);
        check("rst_frames",   bus.frames_sent, 16'h0000);
        nreset = 1'b1;
        exp_frames = 16'h0000;
        repeat (2) @(posedge clk);
        #1;

        // Known-answer frame "123456789"
        p.delete();
        for (int i = 0; i < 9; i++) p.push_back(8'h31 + 8'(i));
        one_frame("kat", p);
        check("kat_active_cycles", blen.size() > 0 ? blen[0] : 0, LEN_123);
`ifndef ETH_TX_PAD_EN
        if (obs.size() >= 21) begin
            check("kat_fcs0", obs[17], 8'h26);
            check("kat_fcs1", obs[18], 8'h39);
            check("kat_fcs2", obs[19], 8'hF4);
            check("kat_fcs3", obs[20], 8'hCB);
        end
`endif

        // Single byte, short, and long random payloads
        one_frame("one_byte", rand_payload(1));
        one_frame("short",    rand_payload($urandom_range(2, 59)));
        one_frame("long",     rand_payload($urandom_range(61, 100)));

        // Back-to-back with in_valid held through the IFG
        pa = rand_payload($urandom_range(1, 40));
        pb = rand_payload($urandom_range(1, 40));
        start_log();
        send(pa, -1, -1);
        send(pb, -1, -1);
        wait_end();
        analyse();
        exp_frames = exp_frames + 16'd2;
        check("b2b_nbursts", blen.size(), 2);
        check_burst("b2b_a", 0, frame_of(pa));
        check_burst("b2b_b", 1, frame_of(pb));
        check("b2b_gap", gaps.size() > 0 ? gaps[0] : -1, IFG);
        check("b2b_frames", bus.frames_sent, exp_frames);

        // Underrun after 5 of 20 bytes
        p = rand_payload(20);
        fr = frame_of(p);
        e13.delete();
        for (int i = 0; i < 13; i++) e13.push_back(fr[i]);
        start_log();
        send(p, 5, -1);
        wait_end();
        analyse();
        check("und_nbursts", blen.size(), 1);
        check_burst("und", 0, e13);
        check("und_err_cycles", n_err, 1);
        check("und_pulses", n_und, 1);
        check("und_err_data", err_data, 8'h00);
        check("und_pulse_pos", und_idx, err_idx);
        check("und_err_pos", err_idx, last11 + 1);
        check("und_frames", bus.frames_sent, exp_frames);

        // Reset while byte 30 is presented
        p = rand_payload(40);
        send(p, -1, 29);
        nreset = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_ctl",    bus.tx_ctl,      2'b00);
        check("mid_rst_ready",  bus.in_ready,    1'b0);
        check("mid_rst_frames", bus.frames_sent, 16'h0000);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nreset = 1'b1;
        exp_frames = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        one_frame("post_rst", rand_payload($urandom_range(10, 50)));

        // frames_sent wrap
        force dut.frames_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.frames_q;
        @(posedge clk);
        #1;
        check("wrap_preload", bus.frames_sent, 16'hFFFF);
        exp_frames = 16'hFFFF;
        one_frame("wrap", rand_payload($urandom_range(1, 30)));
        check("wrap_zero", bus.frames_sent, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
